// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer: FSM state encoding
// and default timing for the 27 MHz board oscillator.
// Imported by button_debouncer; sync_ff is standalone and needs nothing here.
package debounce_pkg;

    localparam int CLK_HZ              = 27_000_000;
    localparam int DEBOUNCE_MS         = 10;
    localparam int LONG_MS             = 1000;
    localparam int DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;  // 270000
    localparam int DEF_LONG_CYCLES     = (CLK_HZ / 1000) * LONG_MS;      // 27000000

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] ST_PRESSED      = 3'd2;
    localparam logic [2:0] ST_LONG_HELD    = 3'd3;
    localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        PRESS_WAIT   = ST_PRESS_WAIT,
        PRESSED      = ST_PRESSED,
        LONG_HELD    = ST_LONG_HELD,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Purpose: STAGES-deep flop chain bringing an asynchronous bit into clk.
// Latency: STAGES cycles from d to q.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised output).
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Purpose: turns a raw active-low button into a debounced level plus
//   press / release / long-press single-cycle strobes.
// Ports: clk, rst_n (async active-low), btn_n (raw, async, 0 = pressed),
//   btn_level, press_pulse, release_pulse, long_press_pulse (all registered).
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int              CW        = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0]   DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   LONG_LAST = CW'(LONG_CYCLES - 1);

    logic w_sync_q;
    logic w_btn_s;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_deb_cnt, w_deb_nxt;
    logic [CW-1:0] r_hold_cnt, w_hold_nxt;
    logic          r_long_flag, w_long_flag_nxt;
    logic          w_press_evt, w_release_evt, w_long_evt;
    logic          r_press_q, r_release_q, r_long_q;
    logic          r_level, r_press, r_release, r_long;
    logic [CW-1:0] w_deb_inc, w_hold_inc;

    // Resets to 1 so a button held through reset still reads as released.
    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_n),
        .q     (w_sync_q)
    );

    assign w_btn_s = ~w_sync_q;

    // Saturating increments: counters never wrap.
    assign w_deb_inc  = (r_deb_cnt  == '1) ? r_deb_cnt  : r_deb_cnt  + CW'(1);
    assign w_hold_inc = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_long_flag <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_deb_cnt   <= w_deb_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_long_flag <= w_long_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_deb_nxt       = r_deb_cnt;
        w_hold_nxt      = r_hold_cnt;
        w_long_flag_nxt = r_long_flag;
        w_press_evt     = 1'b0;
        w_release_evt   = 1'b0;
        w_long_evt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_deb_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = PRESSED;
                    w_hold_nxt  = '0;
                    w_press_evt = 1'b1;
                end else begin
                    w_deb_nxt = w_deb_inc;
                end
            end
            PRESSED: begin
                if (!w_btn_s) begin
                    w_state_nxt     = RELEASE_WAIT;
                    w_deb_nxt       = '0;
                    w_long_flag_nxt = 1'b0;
                end else if (r_hold_cnt == LONG_LAST) begin
                    w_state_nxt = LONG_HELD;
                    w_long_evt  = 1'b1;
                end else begin
                    w_hold_nxt = w_hold_inc;
                end
            end
            LONG_HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt     = RELEASE_WAIT;
                    w_deb_nxt       = '0;
                    w_long_flag_nxt = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // Glitch back to pressed keeps hold_cnt, so the long press
                // is neither restarted nor fired a second time.
                if (w_btn_s) begin
                    w_state_nxt = r_long_flag ? LONG_HELD : PRESSED;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_evt = 1'b1;
                end else begin
                    w_deb_nxt = w_deb_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Events are staged twice so strobes appear on the cycle after the
    // state transition has been registered, giving the documented
    // SYNC_STAGES + DEBOUNCE_CYCLES + 1 press/release latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press_q   <= 1'b0;
            r_release_q <= 1'b0;
            r_long_q    <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
            r_level     <= 1'b0;
        end else begin
            r_press_q   <= w_press_evt;
            r_release_q <= w_release_evt;
            r_long_q    <= w_long_evt;
            r_press     <= r_press_q;
            r_release   <= r_release_q;
            r_long      <= r_long_q;
            if (r_press_q) begin
                r_level <= 1'b1;
            end else if (r_release_q) begin
                r_level <= 1'b0;
            end
        end
    end

    assign btn_level        = r_level;
    assign press_pulse      = r_press;
    assign release_pulse    = r_release;
    assign long_press_pulse = r_long;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    localparam int S   = 2;
    localparam int D   = 8;
    localparam int L   = 40;
    localparam int LAT = S + D + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_n;
    logic btn_level, press_pulse, release_pulse, long_press_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    button_debouncer #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .btn_n            (btn_n),
        .btn_level        (btn_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a level change is accepted once the synchronised
    // input has disagreed with the accepted level for D+1 consecutive
    // samples; hold time counts samples pressed-after-pressed; strobes
    // appear one cycle after acceptance.
    logic [S-1:0] m_hist;
    logic m_bs, m_acc, m_prev_bs, m_long_done;
    logic m_ev_press, m_ev_rel, m_ev_long;
    logic m_press, m_rel, m_long, m_level;
    int   m_run, m_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist = '1; m_acc = 0; m_prev_bs = 0; m_long_done = 0;
            m_run = 0; m_hold = 0;
            m_ev_press = 0; m_ev_rel = 0; m_ev_long = 0;
            m_press = 0; m_rel = 0; m_long = 0; m_level = 0;
        end else begin
            m_bs   = ~m_hist[S-1];
            m_hist = {m_hist[S-2:0], btn_n};
            m_press = m_ev_press; m_rel = m_ev_rel; m_long = m_ev_long;
            if (m_ev_press) m_level = 1;
            if (m_ev_rel)   m_level = 0;
            m_ev_press = 0; m_ev_rel = 0; m_ev_long = 0;
            if (m_acc && m_bs && m_prev_bs && !m_long_done) begin
                m_hold++;
                if (m_hold == L) begin
                    m_ev_long = 1; m_long_done = 1;
                end
            end
            if (m_bs != m_acc) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_acc = m_bs; m_run = 0;
                    if (m_bs) begin
                        m_ev_press = 1; m_hold = 0; m_long_done = 0;
                    end else begin
                        m_ev_rel = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_prev_bs = m_bs;
        end
    end

    // Observation log: strobe counts/times from DUT and model, and
    // cycles where DUT outputs disagree with the model.
    int n_press = 0, n_rel = 0, n_long = 0, n_multi = 0, n_mism = 0;
    int m_npress = 0, m_nrel = 0, m_nlong = 0;
    int last_press = -1, last_rel = -1, last_long = -1;

    always @(negedge clk) begin
        if ({btn_level, press_pulse, release_pulse, long_press_pulse} !==
            {m_level, m_press, m_rel, m_long}) n_mism++;
        if (press_pulse === 1'b1)      begin n_press++; last_press = cyc; end
        if (release_pulse === 1'b1)    begin n_rel++;   last_rel   = cyc; end
        if (long_press_pulse === 1'b1) begin n_long++;  last_long  = cyc; end
        if (int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse) > 1) n_multi++;
        if (m_press) m_npress++;
        if (m_rel)   m_nrel++;
        if (m_long)  m_nlong++;
    end

    task automatic hold_btn(input logic v, input int n);
        btn_n = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {btn_level, press_pulse, release_pulse, long_press_pulse});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 0000",
                     {btn_level, press_pulse, release_pulse, long_press_pulse});
        end
    endtask

    task automatic test_clean_press;
        int p0, l0, r0, mm, e0;
        p0 = n_press; l0 = n_long; r0 = n_rel; mm = n_mism;
        e0 = cyc + 1;
        hold_btn(1'b0, 65);
        n_tests++;
        if (n_press - p0 != 1 || last_press != e0 + LAT) begin
            n_fail++;
            $display("FAIL clean_press: count %0d at cycle %0d, expected 1 at %0d",
                     n_press - p0, last_press, e0 + LAT);
        end
        n_tests++;
        if (btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_level: got %b expected 1", btn_level);
        end
        n_tests++;
        if (n_long - l0 != 1 || last_long != last_press + L) begin
            n_fail++;
            $display("FAIL clean_long: count %0d at cycle %0d, expected 1 at %0d",
                     n_long - l0, last_long, last_press + L);
        end
        e0 = cyc + 1;
        hold_btn(1'b1, 20);
        n_tests++;
        if (n_rel - r0 != 1 || last_rel != e0 + LAT || btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_release: count %0d at cycle %0d level %b, expected 1 at %0d level 0",
                     n_rel - r0, last_rel, btn_level, e0 + LAT);
        end
        n_tests++;
        if (n_mism != mm) begin
            n_fail++;
            $display("FAIL clean_model: %0d mismatching cycles, expected 0", n_mism - mm);
        end
    endtask

    task automatic test_bounce;
        int s0, mm;
        s0 = n_press + n_rel + n_long; mm = n_mism;
        for (int i = 0; i < 4; i++) begin
            hold_btn(1'b0, 5);
            hold_btn(1'b1, 3);
        end
        hold_btn(1'b1, 15);
        n_tests++;
        if (n_press + n_rel + n_long != s0 || btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_reject: strobes %0d level %b, expected 0 and 0",
                     n_press + n_rel + n_long - s0, btn_level);
        end
        n_tests++;
        if (n_mism != mm) begin
            n_fail++;
            $display("FAIL bounce_model: %0d mismatching cycles, expected 0", n_mism - mm);
        end
    endtask

    task automatic test_short_press;
        int p0, r0, l0, e0;
        p0 = n_press; r0 = n_rel; l0 = n_long;
        hold_btn(1'b0, 20);
        e0 = cyc + 1;
        hold_btn(1'b1, 30);
        n_tests++;
        if (n_press - p0 != 1 || n_long - l0 != 0) begin
            n_fail++;
            $display("FAIL short_press: press %0d long %0d, expected 1 and 0",
                     n_press - p0, n_long - l0);
        end
        n_tests++;
        if (n_rel - r0 != 1 || last_rel != e0 + LAT) begin
            n_fail++;
            $display("FAIL short_release: count %0d at cycle %0d, expected 1 at %0d",
                     n_rel - r0, last_rel, e0 + LAT);
        end
    endtask

    task automatic test_release_glitch;
        int r0, l0, mm;
        r0 = n_rel; l0 = n_long; mm = n_mism;
        hold_btn(1'b0, LAT + 1 + 20);
        hold_btn(1'b1, 4);
        hold_btn(1'b0, 60);
        n_tests++;
        if (n_rel - r0 != 0 || n_long - l0 != 1) begin
            n_fail++;
            $display("FAIL glitch_hold: release %0d long %0d, expected 0 and 1",
                     n_rel - r0, n_long - l0);
        end
        hold_btn(1'b1, 20);
        n_tests++;
        if (n_rel - r0 != 1 || n_long - l0 != 1 || n_mism != mm) begin
            n_fail++;
            $display("FAIL glitch_release: release %0d long %0d mism %0d, expected 1 1 0",
                     n_rel - r0, n_long - l0, n_mism - mm);
        end
    endtask

    task automatic test_long_release;
        int r0, l0;
        r0 = n_rel; l0 = n_long;
        hold_btn(1'b0, 60);
        hold_btn(1'b1, 20);
        n_tests++;
        if (n_long - l0 != 1 || n_rel - r0 != 1 || last_rel <= last_long || btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL long_release: long %0d rel %0d rel_cyc %0d long_cyc %0d level %b, expected 1 1 later 0",
                     n_long - l0, n_rel - r0, last_rel, last_long, btn_level);
        end
    endtask

    task automatic test_reset_mid_press;
        int p0, r0, e0;
        hold_btn(1'b0, 20);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 0000",
                     {btn_level, press_pulse, release_pulse, long_press_pulse});
        end
        @(negedge clk);
        @(negedge clk);
        p0 = n_press; r0 = n_rel;
        rst_n = 1'b1;
        e0 = cyc + 1;
        hold_btn(1'b0, 15);
        n_tests++;
        if (n_press - p0 != 1 || last_press != e0 + LAT || n_rel - r0 != 0) begin
            n_fail++;
            $display("FAIL reset_mid_repress: press %0d at %0d rel %0d, expected 1 at %0d rel 0",
                     n_press - p0, last_press, n_rel - r0, e0 + LAT);
        end
        hold_btn(1'b1, 20);
    endtask

    task automatic test_random;
        int mm, p0, r0, l0, mp0, mr0, ml0;
        mm = n_mism; p0 = n_press; r0 = n_rel; l0 = n_long;
        mp0 = m_npress; mr0 = m_nrel; ml0 = m_nlong;
        for (int i = 0; i < 60; i++) begin
            hold_btn(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end
        hold_btn(1'b0, 70);
        for (int i = 0; i < 20; i++) begin
            hold_btn(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        end
        hold_btn(1'b1, 30);
        n_tests++;
        if (n_mism != mm) begin
            n_fail++;
            $display("FAIL random_model: %0d mismatching cycles, expected 0", n_mism - mm);
        end
        n_tests++;
        if (n_press - p0 != m_npress - mp0 || n_rel - r0 != m_nrel - mr0 || n_long - l0 != m_nlong - ml0) begin
            n_fail++;
            $display("FAIL random_counts: press/rel/long %0d/%0d/%0d, expected %0d/%0d/%0d",
                     n_press - p0, n_rel - r0, n_long - l0,
                     m_npress - mp0, m_nrel - mr0, m_nlong - ml0);
        end
        n_tests++;
        if (n_multi != 0) begin
            n_fail++;
            $display("FAIL one_strobe: %0d cycles with several strobes, expected 0", n_multi);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_press();
        test_release_glitch();
        test_long_release();
        test_reset_mid_press();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
